seg7_digit_reader: RTL and testbench
====================================

# seg7_digit_reader

Reads back a 7-segment drive bus, such as the output of our BCD-to-7-segment decoder, and recovers the displayed digit. It filters transient patterns with a stability counter and decodes only locked patterns into BCD. Each lock reports one of: digit, blank or illegal pattern. It sits on the display side of the counter/decoder chain as a self-check and loop-back observer.

## Interface
- STABLE_CYCLES, 4, consecutive matching samples required after a change before lock; legal range 1..15.
- CP  input  1  clock; all state updates on rising edge.
- MR  input  1  synchronous active-high reset.
- Seg  input  8  segment bus, active-high: Seg[0]=a .. Seg[6]=g, Seg[7]=dp.
- Dn  output  4  last locked valid digit, BCD 0..9, registered.
- Valid  output  1  one-cycle pulse: a valid digit has just locked into Dn.
- Blank  output  1  level: the currently locked pattern is all-off.
- Err  output  1  one-cycle pulse: an illegal pattern has just locked.
- SeqErr  output  1  one-cycle pulse: sequence violation (see Configuration).
- DigCnt  output  8  count of valid-digit locks, saturating at 255.

## Operation
- Seg[7] (dp) is masked everywhere: it is not used in the compare and not used in the decode.
- A sample register s_q holds Seg[6:0] and is loaded every cycle.
- A counter cnt, width 4, measures stability.
- States:
  - TRACK: waiting for stability.
  - LOCKED: a pattern has been classified.
- Each edge, the input Seg[6:0] is compared with s_q:
  - Differs: cnt<=0, state<=TRACK, Blank<=0.
  - Same, in TRACK, with cnt<STABLE_CYCLES-1: cnt<=cnt+1.
  - Same, in TRACK, with cnt==STABLE_CYCLES-1: state<=LOCKED and the pattern is classified.
  - Same, in LOCKED: no action, and no repeated pulses.
- Accepted codes, by g..a hex value:
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5.
  - 0x7C or 0x7D=6 (the pattern with the top tail and the pattern without it are both accepted).
  - 0x07=7, 0x7F=8.
  - 0x67 or 0x6F=9 (with and without tail).
- Classification on lock:
  - Accepted code: Dn<=digit, Valid pulse, DigCnt<=DigCnt+1 unless it is already 255.
  - 0x00: Blank<=1, Dn held, no Valid, DigCnt unchanged.
  - Any other code: Err pulse, Dn held, Blank 0.
- Valid, Err and SeqErr are high for exactly the one cycle following the lock edge.
- Valid and Err are mutually exclusive.
- Blank stays high while LOCKED on 0x00. It clears on the edge that sees a changed input.

## Timing
- Reset values (applied on the edge where MR=1): state=TRACK, s_q=0x00, cnt=0, Dn=0, Valid=0, Blank=0, Err=0, SeqErr=0, DigCnt=0. Sequence history is empty.
- MR takes precedence over every other event.
- MR asserted mid-TRACK or mid-pulse: a pending lock is discarded, and a pulse that would have started on that edge is suppressed.
- Latency: a new pattern applied before edge k and held constant produces the lock pulse after edge k+STABLE_CYCLES. The pattern is therefore sampled STABLE_CYCLES+1 times.
- A change on any edge before the lock restarts the count, including a change back to the previously locked pattern; that pattern then re-locks and pulses again.
- Held 0x00 after reset: Blank rises after edge STABLE_CYCLES (s_q already matches).
- dp toggling alone never restarts the count and never causes a re-lock.

## Configuration
- SEG7_READER_SEQ_CHECK_EN defined:
  - The block keeps the last valid digit and a history flag.
  - On a valid lock with the history flag set, if the digit is not equal to (prev+1) mod 10, SeqErr pulses in the same cycle as Valid.
  - Blank and illegal locks do not alter the history. The sequence 9, blank, 0 is therefore legal.
  - MR clears the history.
- Macro undefined: SeqErr is tied to 0 and there are no history registers.

## Test plan
- Reset, Seg=0x00 held, STABLE_CYCLES=4 -> Blank=1 after 4th edge; Dn=0, Valid=0, DigCnt=0.
- Seg=0x4F held 5 edges -> Valid pulse after 5th edge, Dn=3, DigCnt=1; hold 20 more edges -> no further pulses.
- Seg toggles 0x4F/0x66 every 2 cycles, then 0x66 held -> no lock during toggling; a single Valid with Dn=4 after 5 stable edges.
- Seg=0x49 held -> Err pulse, Dn unchanged, Blank=0; then 0x7C and 0x7D each lock -> Dn=6 both times.
- Macro on: lock 8, 9, 0x00, 0 -> no SeqErr; then lock 5 -> SeqErr with Valid; Macro off: same sequence -> SeqErr stays 0.
- 256 valid locks -> DigCnt=255 saturates; MR during the count phase of a lock -> all outputs reset, no pulse.

Source files
------------

// File: rtl/seg7_digit_reader.sv
// Observes a 7-segment drive bus, waits for a stable pattern and decodes it to BCD.
// Optional sequence checking (consecutive digits) is enabled by SEG7_READER_SEQ_CHECK_EN.
module seg7_digit_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       CP,
    input  logic       MR,
    input  logic [7:0] Seg,
    output logic [3:0] Dn,
    output logic       Valid,
    output logic       Blank,
    output logic       Err,
    output logic       SeqErr,
    output logic [7:0] DigCnt
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned DCNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        TRACK  = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q;
    logic [SEG_W-1:0]    s_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DIG_W-1:0]    dn_q;
    logic                valid_q;
    logic                blank_q;
    logic                err_q;
    logic [DCNT_W-1:0]   dig_cnt_q;

    logic [SEG_W-1:0]    seg_c;
    logic                seg_dp_unused_c;
    logic                dig_ok_c;
    logic [DIG_W-1:0]    dig_c;

    // Decimal point never participates in stability or decode.
    assign seg_c           = Seg[SEG_W-1:0];
    assign seg_dp_unused_c = Seg[7];

    // Pattern-to-digit table; both tail variants of 6 and 9 are accepted.
    always_comb begin
        dig_ok_c = 1'b1;
        dig_c    = '0;
        case (seg_c)
            7'h3F:        dig_c = 4'd0;
            7'h06:        dig_c = 4'd1;
            7'h5B:        dig_c = 4'd2;
            7'h4F:        dig_c = 4'd3;
            7'h66:        dig_c = 4'd4;
            7'h6D:        dig_c = 4'd5;
            7'h7C, 7'h7D: dig_c = 4'd6;
            7'h07:        dig_c = 4'd7;
            7'h7F:        dig_c = 4'd8;
            7'h67, 7'h6F: dig_c = 4'd9;
            default:      dig_ok_c = 1'b0;
        endcase
    end

`ifdef SEG7_READER_SEQ_CHECK_EN
    logic [DIG_W-1:0] prev_q;
    logic             hist_q;
    logic             seq_err_q;
    logic [DIG_W-1:0] next_exp_c;

    assign next_exp_c = (prev_q == 4'd9) ? 4'd0 : prev_q + DIG_W'(1);
    assign SeqErr     = seq_err_q;
`else
    assign SeqErr = 1'b0;
`endif

    always_ff @(posedge CP) begin
        if (MR) begin
            state_q   <= TRACK;
            s_q       <= '0;
            cnt_q     <= '0;
            dn_q      <= '0;
            valid_q   <= 1'b0;
            blank_q   <= 1'b0;
            err_q     <= 1'b0;
            dig_cnt_q <= '0;
`ifdef SEG7_READER_SEQ_CHECK_EN
            prev_q    <= '0;
            hist_q    <= 1'b0;
            seq_err_q <= 1'b0;
`endif
        end else begin
            s_q     <= seg_c;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef SEG7_READER_SEQ_CHECK_EN
            seq_err_q <= 1'b0;
`endif
            if (seg_c != s_q) begin
                cnt_q   <= '0;
                state_q <= TRACK;
                blank_q <= 1'b0;
            end else if (state_q == TRACK) begin
                if (cnt_q != CNT_LAST) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else begin
                    // Pattern has been stable long enough: classify exactly once.
                    state_q <= LOCKED;
                    if (dig_ok_c) begin
                        dn_q    <= dig_c;
                        valid_q <= 1'b1;
                        if (dig_cnt_q != {DCNT_W{1'b1}}) begin
                            dig_cnt_q <= dig_cnt_q + DCNT_W'(1);
                        end
`ifdef SEG7_READER_SEQ_CHECK_EN
                        seq_err_q <= hist_q && (dig_c != next_exp_c);
                        prev_q    <= dig_c;
                        hist_q    <= 1'b1;
`endif
                    end else if (seg_c == '0) begin
                        blank_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign Dn     = dn_q;
    assign Valid  = valid_q;
    assign Blank  = blank_q;
    assign Err    = err_q;
    assign DigCnt = dig_cnt_q;

endmodule

// File: tb/tb_seg7_digit_reader.sv
// Scoreboard bench for seg7_digit_reader: directed patterns push expected lock events,
// a negedge monitor pops and compares every Valid/Err pulse and every Blank rise.
module tb_seg7_digit_reader;

    localparam int unsigned S = 4;
    localparam int K_VALID = 0;
    localparam int K_ERR   = 1;
    localparam int K_BLANK = 2;
    localparam int K_NONE  = -1;

    typedef struct {
        int         kind;
        int         edge_at;
        logic [3:0] dn;
        logic [7:0] cnt;
        logic       seqerr;
    } exp_t;

    logic       CP;
    logic       MR;
    logic [7:0] Seg;
    logic [3:0] Dn;
    logic       Valid;
    logic       Blank;
    logic       Err;
    logic       SeqErr;
    logic [7:0] DigCnt;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    // Reference state, updated only from the hand-written stimulus list.
    logic [3:0] m_dn;
    logic [7:0] m_cnt;
    logic [3:0] m_prev;
    logic       m_hist;

    seg7_digit_reader #(.STABLE_CYCLES(S)) dut (
        .CP     (CP),
        .MR     (MR),
        .Seg    (Seg),
        .Dn     (Dn),
        .Valid  (Valid),
        .Blank  (Blank),
        .Err    (Err),
        .SeqErr (SeqErr),
        .DigCnt (DigCnt)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    always @(posedge CP) edge_n = edge_n + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks = checks + 1;
        if (act != expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_n);
        end
    endtask

    task automatic push_exp(input int kind, input int at, input logic [3:0] dig);
        exp_t e;
        logic se;
        se = 1'b0;
        if (kind == K_VALID) begin
`ifdef SEG7_READER_SEQ_CHECK_EN
            se     = m_hist && (dig != ((m_prev == 4'd9) ? 4'd0 : m_prev + 4'd1));
            m_prev = dig;
            m_hist = 1'b1;
`endif
            m_dn = dig;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        e.kind    = kind;
        e.edge_at = at;
        e.dn      = m_dn;
        e.cnt     = m_cnt;
        e.seqerr  = se;
        expq.push_back(e);
    endtask

    // Entered at a negedge; drives the pattern for 'hold' sampling edges.
    task automatic apply(input logic [7:0] seg, input int hold, input int kind, input logic [3:0] dig);
        Seg = seg;
        if (kind != K_NONE) push_exp(kind, edge_n + 1 + S, dig);
        repeat (hold) @(negedge CP);
    endtask

    task automatic reset_dut();
        MR = 1'b1;
        @(negedge CP);
        MR     = 1'b0;
        m_dn   = 4'd0;
        m_cnt  = 8'd0;
        m_prev = 4'd0;
        m_hist = 1'b0;
        chk("rst_dn", int'(Dn), 0);
        chk("rst_valid", int'(Valid), 0);
        chk("rst_blank", int'(Blank), 0);
        chk("rst_err", int'(Err), 0);
        chk("rst_seqerr", int'(SeqErr), 0);
        chk("rst_digcnt", int'(DigCnt), 0);
    endtask

    // Monitor: every pulse or Blank rise must match the head of the queue.
    logic blank_d = 1'b0;
    always @(negedge CP) begin
        exp_t e;
        int   kind;
        if (Valid || Err || (Blank && !blank_d)) begin
            kind = Valid ? K_VALID : (Err ? K_ERR : K_BLANK);
            if (Valid && Err) chk("valid_err_exclusive", 1, 0);
            if (expq.size() == 0) begin
                chk("unexpected_event_kind", kind, K_NONE);
            end else begin
                e = expq.pop_front();
                chk("ev_kind", kind, e.kind);
                chk("ev_edge", edge_n, e.edge_at);
                chk("ev_dn", int'(Dn), int'(e.dn));
                chk("ev_digcnt", int'(DigCnt), int'(e.cnt));
                chk("ev_seqerr", int'(SeqErr), int'(e.seqerr));
                if (kind != K_BLANK) chk("ev_blank_low", int'(Blank), 0);
            end
        end else if (SeqErr) begin
            chk("seqerr_without_valid", 1, 0);
        end
        blank_d <= Blank;
    end

    initial begin
        MR  = 1'b1;
        Seg = 8'h00;
        reset_dut();

        // Held blank after reset: s_q already matches, lock on edge R+S.
        push_exp(K_BLANK, edge_n + S, 4'd0);
        repeat (6) @(negedge CP);

        apply(8'h4F, 25, K_VALID, 4'd3);

        // Toggling too fast to lock, then settle on 4.
        apply(8'h66, 2, K_NONE, 4'd0);
        apply(8'h4F, 2, K_NONE, 4'd0);
        apply(8'h66, 2, K_NONE, 4'd0);
        apply(8'h4F, 2, K_NONE, 4'd0);
        apply(8'h66, 6, K_VALID, 4'd4);

        apply(8'h49, 6, K_ERR, 4'd0);
        apply(8'h7C, 6, K_VALID, 4'd6);
        apply(8'h7D, 6, K_VALID, 4'd6);

        // dp toggling alone must not restart the count or re-lock.
        apply(8'h87, 1, K_VALID, 4'd7);
        for (int i = 0; i < 10; i++) begin
            Seg = (i % 2 == 0) ? 8'h07 : 8'h87;
            @(negedge CP);
        end

        // Sequence history: 8, 9, blank, 0 legal; then 5 breaks the order.
        reset_dut();
        apply(8'h7F, 6, K_VALID, 4'd8);
        apply(8'h6F, 6, K_VALID, 4'd9);
        apply(8'h00, 6, K_BLANK, 4'd0);
        apply(8'h3F, 6, K_VALID, 4'd0);
        apply(8'h6D, 6, K_VALID, 4'd5);

        // Saturation of the lock counter.
        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 0) apply(8'h06, 6, K_VALID, 4'd1);
            else            apply(8'h5B, 6, K_VALID, 4'd2);
        end
        chk("digcnt_saturated", int'(DigCnt), 255);

        // Reset on the would-be lock edge: pulse suppressed, relock afterwards.
        Seg = 8'h3F;
        repeat (S) @(negedge CP);
        reset_dut();
        push_exp(K_VALID, edge_n + 1 + S, 4'd0);
        repeat (8) @(negedge CP);

        for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge CP);
        chk("queue_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
